// File: rtl/cpu8_pkg.sv
// Shared CPU bus definitions: widths, bus FSM encodings and I/O register map.
package cpu8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam int unsigned GPIO_OUT = 0;
  localparam int unsigned GPIO_IN  = 1;
  localparam int unsigned STATUS   = 2;

  localparam logic [DATA_W-1:0] UNMAPPED_READ = 8'hFF;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM: write and registered read on enabled edges.
module ram_sp #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Storage array and read register; contents survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus target: wait-state handshake, RAM window and three I/O registers.
module mem_responder
  import cpu8_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned ADDR_WIDTH     = ADDR_W,
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned WAIT_STATES    = 1,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = 16'hFF00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_rw,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] mem_Q,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic [DATA_WIDTH-1:0] gpio_out,
  input  logic [DATA_WIDTH-1:0] gpio_in
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

  bus_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic                    lat_rw;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic                    sticky_err;
  logic                    rsp_ram;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_io;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  logic                    acc_rw;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    commit_c;
  logic                    hit_ram, hit_gout, hit_gin, hit_stat, hit_none;
  logic [DATA_WIDTH-1:0]   rd_io_c;

  // Select the access being committed (bus directly when committing from IDLE) and decode it.
  always_comb begin
    acc_rw   = lat_rw;
    acc_addr = lat_addr;
    acc_data = lat_data;
    if (state == IDLE) begin
      acc_rw   = mem_rw;
      acc_addr = mem_addr;
      acc_data = mem_data;
    end

    commit_c = 1'b0;
    if (state == IDLE && mem_req && WAIT_STATES == 0) commit_c = 1'b1;
    if (state == WAIT && cnt == CNT_W'(1))           commit_c = 1'b1;

    hit_ram  = 32'(acc_addr) < 32'(RAM_DEPTH);
    hit_gout = !hit_ram && (acc_addr == IO_BASE + ADDR_WIDTH'(GPIO_OUT));
    hit_gin  = !hit_ram && (acc_addr == IO_BASE + ADDR_WIDTH'(GPIO_IN));
    hit_stat = !hit_ram && (acc_addr == IO_BASE + ADDR_WIDTH'(STATUS));
    hit_none = !(hit_ram || hit_gout || hit_gin || hit_stat);

    rd_io_c = DATA_WIDTH'(UNMAPPED_READ);
    if (hit_gout)      rd_io_c = gpio_out;
    else if (hit_gin)  rd_io_c = gpio_in;
    else if (hit_stat) rd_io_c = {{(DATA_WIDTH-1){1'b0}}, sticky_err};
  end

  ram_sp #(
    .AW(RAM_ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (commit_c && !rst),
    .we   (acc_rw && hit_ram),
    .addr (acc_addr[RAM_ADDR_WIDTH-1:0]),
    .wdata(acc_data),
    .rdata(ram_rdata)
  );

  // Bus FSM, commit-time side effects and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      mem_Q      <= '0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      gpio_out   <= '0;
      sticky_err <= 1'b0;
      rsp_ram    <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_io     <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            lat_rw   <= mem_rw;
            lat_addr <= mem_addr;
            lat_data <= mem_data;
            cnt      <= CNT_W'(WAIT_STATES);
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          mem_ready <= 1'b1;
          mem_err   <= rsp_err;
          if (!lat_rw) mem_Q <= rsp_ram ? ram_rdata : rsp_io;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (commit_c) begin
        rsp_ram    <= hit_ram;
        rsp_err    <= hit_none;
        rsp_io     <= rd_io_c;
        if (acc_rw && hit_gout) gpio_out <= acc_data;
        sticky_err <= (sticky_err && !(acc_rw && hit_stat && acc_data[0])) || hit_none;
      end
    end
  end

endmodule
